// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared constants, load-type codes and load decode helper for mem_wb
package mem_wb_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LW  = 3'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef struct packed {
        logic is_byte;
        logic is_half;
        logic is_signed;
    } ld_sel_t;

    // Reserved codes fall through to the all-zero selector, i.e. a full-word load.
    function automatic ld_sel_t decode_load(input logic [2:0] lt);
        ld_sel_t s;
        s = '0;
        case (lt)
            LT_LB:  begin s.is_byte = 1'b1; s.is_signed = 1'b1; end
            LT_LBU: s.is_byte = 1'b1;
            LT_LH:  begin s.is_half = 1'b1; s.is_signed = 1'b1; end
            LT_LHU: s.is_half = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wb_load_ext.sv
// rtl/mem_wb_load_ext.sv - combinational byte-lane select, sign/zero extension and misalignment detect
module load_ext
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        lane,
    input  logic [2:0]        ltype,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    ld_sel_t     sel;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        sel        = decode_load(ltype);
        byte_v     = raw[{lane, 3'b000} +: 8];
        half_v     = raw[{lane[1], 4'b0000} +: 16];
        data       = raw;
        misaligned = 1'b0;
        if (sel.is_byte) begin
            data = {{(DATA_W-8){sel.is_signed & byte_v[7]}}, byte_v};
        end else if (sel.is_half) begin
            data       = {{(DATA_W-16){sel.is_signed & half_v[15]}}, half_v};
            misaligned = lane[0];
        end else begin
            misaligned = |lane;
        end
    end

endmodule

// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register and register-file writeback; WB_RETIRE_CNT_EN adds wb_retire_cnt
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_load_type,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall_wb,
    input  logic              flush,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exc,
    output logic [DATA_W-1:0] wb_badaddr
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       wb_retire_cnt
`endif
);

    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic              exc_q, exc_d;
    logic              written_q, written_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] badaddr_q, badaddr_d;

    logic [DATA_W-1:0] ld_data;
    logic              ld_mis;
    logic              accept;
    logic              mis;
    logic              will_write;
    logic [DATA_W-1:0] wdata;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .raw        (mem_rdata),
        .lane       (mem_alu_result[1:0]),
        .ltype      (mem_load_type),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    assign mem_ready  = !stall_wb && !rst;
    assign accept     = mem_valid && mem_ready;
    assign mis        = mem_is_load && ld_mis;
    assign wdata      = mem_is_load ? ld_data : mem_alu_result;
    // r0 and misaligned entries are folded into we at capture so the port stays quiet for them.
    assign will_write = mem_we && !mis && (mem_waddr != '0);

    always_comb begin
        valid_d   = valid_q;
        we_d      = we_q;
        exc_d     = exc_q;
        written_d = written_q;
        addr_d    = addr_q;
        data_d    = data_q;
        badaddr_d = badaddr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            written_d = 1'b0;
            we_d      = will_write;
            exc_d     = mis;
            // Address/data only move when a write is issued, so they hold while wb_we is low.
            if (will_write) begin
                addr_d = mem_waddr;
                data_d = wdata;
            end
            if (mis) begin
                badaddr_d = mem_alu_result;
            end
        end else if (!stall_wb) begin
            valid_d = 1'b0;
        end else begin
            written_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            exc_q     <= 1'b0;
            written_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            badaddr_q <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            exc_q     <= exc_d;
            written_q <= written_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            badaddr_q <= badaddr_d;
        end
    end

    assign wb_we      = valid_q && we_q && !written_q;
    assign wb_exc     = valid_q && exc_q && !written_q;
    assign wb_addr    = addr_q;
    assign wb_data    = data_q;
    assign wb_badaddr = badaddr_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wb_we || wb_exc) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb/tb_mem_wb.sv - directed vector bench for mem_wb (optionally with WB_RETIRE_CNT_EN)
module tb_mem_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_alu_result;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [31:0] mem_rdata;
    logic        stall_wb;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_exc;
    logic [31:0] wb_badaddr;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] wb_retire_cnt;
`endif

    mem_wb dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_alu_result (mem_alu_result),
        .mem_is_load    (mem_is_load),
        .mem_load_type  (mem_load_type),
        .mem_rdata      (mem_rdata),
        .stall_wb       (stall_wb),
        .flush          (flush),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_exc         (wb_exc),
        .wb_badaddr     (wb_badaddr)
`ifdef WB_RETIRE_CNT_EN
        ,
        .wb_retire_cnt  (wb_retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        ld;
        logic [2:0]  lt;
        logic [31:0] rdata;
        logic        e_we;
        logic        e_exc;
        logic [31:0] e_val;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    int pulses   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] alu,
                         input logic ld, input logic [2:0] lt, input logic [31:0] rd);
        mem_valid      = 1'b1;
        mem_we         = we;
        mem_waddr      = wa;
        mem_alu_result = alu;
        mem_is_load    = ld;
        mem_load_type  = lt;
        mem_rdata      = rd;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 5'd5,  32'h0000_1234, 1'b0, 3'd0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_1234};
        vecs[1]  = '{1'b1, 5'd1,  32'h0000_0103, 1'b1, 3'd0, 32'h80FF_0000, 1'b1, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 5'd2,  32'h0000_0103, 1'b1, 3'd1, 32'h80FF_0000, 1'b1, 1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 5'd3,  32'h0000_0102, 1'b1, 3'd0, 32'h80FF_0000, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b1, 5'd4,  32'h0000_0101, 1'b1, 3'd1, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0056};
        vecs[5]  = '{1'b1, 5'd6,  32'h0000_0102, 1'b1, 3'd2, 32'h80FF_0000, 1'b1, 1'b0, 32'hFFFF_80FF};
        vecs[6]  = '{1'b1, 5'd14, 32'h0000_0000, 1'b1, 3'd3, 32'h1234_F00D, 1'b1, 1'b0, 32'h0000_F00D};
        vecs[7]  = '{1'b1, 5'd15, 32'h0000_0000, 1'b1, 3'd2, 32'h0000_7FFF, 1'b1, 1'b0, 32'h0000_7FFF};
        vecs[8]  = '{1'b1, 5'd10, 32'h0000_0100, 1'b1, 3'd4, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 5'd16, 32'h0000_0102, 1'b1, 3'd4, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0102};
        vecs[10] = '{1'b1, 5'd17, 32'h0000_0201, 1'b1, 3'd3, 32'h1111_2222, 1'b0, 1'b1, 32'h0000_0201};
        vecs[11] = '{1'b1, 5'd18, 32'h0000_0004, 1'b1, 3'd7, 32'hCAFE_BABE, 1'b1, 1'b0, 32'hCAFE_BABE};
        vecs[12] = '{1'b1, 5'd19, 32'h0000_0005, 1'b1, 3'd5, 32'hCAFE_BABE, 1'b0, 1'b1, 32'h0000_0005};
        vecs[13] = '{1'b1, 5'd0,  32'h0000_ABCD, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b0, 5'd20, 32'h0000_ABCD, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
        vecs[15] = '{1'b1, 5'd0,  32'h0000_0103, 1'b1, 3'd4, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0103};
        vecs[16] = '{1'b1, 5'd21, 32'h0000_0100, 1'b1, 3'd0, 32'h0000_007F, 1'b1, 1'b0, 32'h0000_007F};

        rst = 1'b1;
        mem_valid = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_alu_result = '0;
        mem_is_load = 1'b0; mem_load_type = '0; mem_rdata = '0;
        stall_wb = 1'b0; flush = 1'b0;

        #12;
        chk1("rst_wb_we", wb_we, 1'b0);
        chk1("rst_wb_exc", wb_exc, 1'b0);
        chk1("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_wb_addr", {27'b0, wb_addr}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_badaddr", wb_badaddr, 32'h0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_cnt", wb_retire_cnt, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].alu, vecs[i].ld, vecs[i].lt, vecs[i].rdata);
            chk1($sformatf("v%0d_ready", i), mem_ready, 1'b1);
            @(negedge clk);
            mem_valid = 1'b0;
            chk1($sformatf("v%0d_we", i), wb_we, vecs[i].e_we);
            chk1($sformatf("v%0d_exc", i), wb_exc, vecs[i].e_exc);
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_addr", i), {27'b0, wb_addr}, {27'b0, vecs[i].waddr});
                chk($sformatf("v%0d_data", i), wb_data, vecs[i].e_val);
            end
            if (vecs[i].e_exc) begin
                chk($sformatf("v%0d_badaddr", i), wb_badaddr, vecs[i].e_val);
            end
            if (vecs[i].e_we || vecs[i].e_exc) exp_cnt++;
            @(negedge clk);
            chk1($sformatf("v%0d_we_drop", i), wb_we, 1'b0);
            chk1($sformatf("v%0d_exc_drop", i), wb_exc, 1'b0);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("table_cnt", wb_retire_cnt, exp_cnt);
`endif

        // back-to-back acceptance, no bubble
        @(negedge clk);
        drive(1'b1, 5'd11, 32'h0000_1111, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        chk1("b2b_we0", wb_we, 1'b1);
        chk("b2b_addr0", {27'b0, wb_addr}, 32'd11);
        drive(1'b1, 5'd12, 32'h0000_2222, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        mem_valid = 1'b0;
        chk1("b2b_we1", wb_we, 1'b1);
        chk("b2b_addr1", {27'b0, wb_addr}, 32'd12);
        chk("b2b_data1", wb_data, 32'h0000_2222);
        @(negedge clk);
        chk1("b2b_drop", wb_we, 1'b0);

        // held entry writes exactly once
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h0000_7777, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        pulses = int'(wb_we);
        chk("stall_addr", {27'b0, wb_addr}, 32'd7);
        stall_wb = 1'b1;
        drive(1'b1, 5'd8, 32'h0000_8888, 1'b0, 3'd0, 32'h0);
        #1;
        chk1("stall_ready0", mem_ready, 1'b0);
        repeat (2) begin
            @(negedge clk);
            pulses += int'(wb_we);
            chk1("stall_ready", mem_ready, 1'b0);
        end
        chk("stall_pulses", pulses, 32'd1);
        stall_wb = 1'b0;
        @(negedge clk);
        mem_valid = 1'b0;
        chk1("release_we", wb_we, 1'b1);
        chk("release_addr", {27'b0, wb_addr}, 32'd8);
        chk("release_data", wb_data, 32'h0000_8888);
        @(negedge clk);
        chk1("release_drop", wb_we, 1'b0);

        // flush wins over same-cycle acceptance
        @(negedge clk);
        drive(1'b1, 5'd9, 32'h0000_9999, 1'b0, 3'd0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mem_valid = 1'b0;
        chk1("flush_we", wb_we, 1'b0);
        chk("flush_addr_hold", {27'b0, wb_addr}, 32'd8);

        // reset in the middle of a stall discards the entry
        @(negedge clk);
        drive(1'b1, 5'd13, 32'h0000_000D, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        chk1("rs_we", wb_we, 1'b1);
        stall_wb = 1'b1;
        mem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk1("rs_we_rst", wb_we, 1'b0);
        chk1("rs_ready_rst", mem_ready, 1'b0);
        chk("rs_addr_rst", {27'b0, wb_addr}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("rs_cnt_rst", wb_retire_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stall_wb = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            pulses += int'(wb_we) + int'(wb_exc);
        end
        chk("rs_no_write", pulses, 32'd0);

`ifdef WB_RETIRE_CNT_EN
        // 4 retires, 1 flushed, 1 misaligned -> 5
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k), 32'(k), 1'b0, 3'd0, 32'h0);
        end
        @(negedge clk);
        drive(1'b1, 5'd22, 32'h0000_0055, 1'b0, 3'd0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 5'd23, 32'h0000_0302, 1'b1, 3'd4, 32'h0);
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("cnt_five", wb_retire_cnt, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
# mem_wb

Pipeline register and writeback stage between the MEM stage and the register file. It accepts one retiring instruction per cycle from MEM over a valid/ready handshake and sign/zero-extends load data by byte lane. It drives the register-file write port (`wb_we`, `wb_addr`, `wb_data`) exactly one cycle after acceptance and flags misaligned loads instead of writing them.

## Interface
- `DATA_W`, 32, datapath width (`WordWidth`/`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset (`RstEnable`)
- `mem_valid` in 1: MEM presents an instruction
- `mem_ready` out 1: WB can accept this cycle
- `mem_we` in 1: instruction writes a register
- `mem_waddr` in ADDR_W: destination register
- `mem_alu_result` in DATA_W: non-load result; for loads, the effective address
- `mem_is_load` in 1: select load data instead of ALU result
- `mem_load_type` in 3: LB=0, LBU=1, LH=2, LHU=3, LW=4; others are reserved and treated as LW
- `mem_rdata` in DATA_W: raw word from data memory, little-endian
- `stall_wb` in 1: hazard unit holds WB
- `flush` in 1: squash the WB entry (exception or redirect)
- `wb_we` out 1, `wb_addr` out ADDR_W, `wb_data` out DATA_W: register-file write port
- `wb_exc` out 1: misaligned-load pulse
- `wb_badaddr` out DATA_W: faulting address, valid with `wb_exc`

## Operation
- State:
  - entry register: valid, we, addr, data, exc
  - `written` flag
- Acceptance:
  - `mem_ready = !stall_wb && !rst`
  - Accept when `mem_valid && mem_ready`.
- Priority at each clock edge:
  - flush: clear valid.
  - else accept: load the entry and clear `written`.
  - else if `!stall_wb`: clear valid.
  - else (stalled): hold the entry and set `written`.
- Load extension (byte lane = `mem_alu_result[1:0]`):
  - LB/LBU: byte lane 0–3, sign/zero-extended.
  - LH/LHU: half `[1]`, sign/zero-extended.
  - LW: full word.
- Misalignment: LH/LHU with `addr[0]=1`, or LW with `addr[1:0]!=0`.
  - Entry is stored with `exc=1` and `we=0`.
  - `wb_badaddr` = `mem_alu_result`.
- Write enable: `wb_we = valid && we && !exc && !written && addr!=0`.
  - Exactly one write per accepted instruction, even across stalls.
  - Writes to r0 are suppressed.
- `wb_exc = valid && exc && !written`, a single pulse.
- A flush in the same cycle as acceptance wins: the incoming instruction is dropped and `wb_we=0` next cycle.
- `wb_addr`/`wb_data` hold their last value while `wb_we=0`; consumers must qualify them with `wb_we`.

## Timing
- Reset (asynchronous, immediate):
  - valid=0, written=0
  - `wb_we=0`, `wb_addr=0`, `wb_data=0`, `wb_exc=0`, `wb_badaddr=0`
  - `mem_ready=0` while `rst` is high
- Latency: accepted at edge N → `wb_we`/`wb_data` valid in cycle N+1 (combinational from registers).
- Register-file same-cycle bypass covers the ID read in cycle N+1. No extra forwarding is produced here.
- Throughput: 1 instruction/cycle with `stall_wb=0`, back-to-back with no bubble.
- `stall_wb` asserted:
  - `mem_ready` drops in the same cycle; MEM must hold its outputs.
  - `wb_we` stays high only in the first cycle of the held entry, then 0 until the next acceptance.
- Reset mid-stall: the entry is discarded; nothing is written after reset deasserts.

## Configuration
- `WB_RETIRE_CNT_EN` defined adds output `wb_retire_cnt` (32 bits).
  - Increments once per entry that produces `wb_we` or `wb_exc`.
  - Wraps modulo 2^32; reset value 0.
  - Flushed and r0 entries do not count unless they raise `wb_exc`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Add to `defines.v`:
  - `LB`/`LBU`/`LH`/`LHU`/`LW` load-type constants
  - `ExcAdel` code
  - the existing `RstEnable`/`WriteEnable`/`RegAddrBus`/`WordWidth` definitions
- One sub-module, `load_ext`: purely combinational. Inputs are raw word, lane, and type; outputs are extended data and misaligned flag.

## Test plan
- Reset, then accept ADDI r5 (`mem_alu_result=0x0000_1234`) → next cycle `wb_we=1`, `wb_addr=5`, `wb_data=0x0000_1234`; following cycle `wb_we=0`.
- LB at address `0x...03` with `mem_rdata=0x80FF_0000` → `wb_data=0xFFFF_FF80`. Same access with LBU → `0x0000_0080`.
- LW at address `0x...02` → `wb_we=0`, `wb_exc=1` for one cycle, `wb_badaddr=0x...02`.
- Accept r7, then hold `stall_wb=1` for 3 cycles → exactly one `wb_we` pulse and `mem_ready=0` throughout. After release, a back-to-back r8 write lands the next cycle.
- `flush` together with accepting r9 → no `wb_we` next cycle. Write to r0 → `wb_we=0`.
- With `WB_RETIRE_CNT_EN`: 4 retires, 1 flush, 1 misaligned load → `wb_retire_cnt=5`. Asserting `rst` mid-run → count 0 immediately.
